interval_sequencer: RTL and testbench

Initiator side of the start/end timer interface. Fires a one-cycle start pulse to an external down-counting interval timer and waits for its end flag. It counts completed intervals and steps a 2-bit phase through 0,1,2,3,0. Each phase lasts a parameterised number of timer intervals. Top-level control logic uses it to pace multi-phase sequences from a single shared timer.

---
 rtl/interval_sequencer_pkg.sv | 32 +++
 rtl/interval_sequencer.sv | 92 +++++++++
 tb/tb_interval_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/interval_sequencer_pkg.sv
// Shared types and helpers for the interval sequencer: FSM state encoding,
// phase identifiers and the per-phase interval count lookup.
package interval_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      ARM  = 2'd2,
      WAIT = 2'd3
   } state_t;

   localparam logic [1:0] PH0 = 2'd0;
   localparam logic [1:0] PH1 = 2'd1;
   localparam logic [1:0] PH2 = 2'd2;
   localparam logic [1:0] PH3 = 2'd3;

   // Interval count of a phase; the counts are passed in because they are
   // parameters of each sequencer instance.
   function automatic int ticks_for(input logic [1:0] ph,
                                    input int t0, input int t1,
                                    input int t2, input int t3);
      int n;
      case (ph)
         PH0:     n = t0;
         PH1:     n = t1;
         PH2:     n = t2;
         default: n = t3;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/interval_sequencer.sv
// Starts an external down-counting interval timer, waits for its end flag and
// steps a 2-bit phase after a per-phase number of completed intervals.
module interval_sequencer
   import interval_pkg::*;
#(
   parameter int TW = 4,
   parameter int T0 = 3,
   parameter int T1 = 1,
   parameter int T2 = 3,
   parameter int T3 = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          hold,
   output logic          tmr_start,
   input  logic          tmr_end,
   output logic [1:0]    phase,
   output logic [TW-1:0] tick_cnt,
   output logic          phase_done,
   output logic          running
);

   if (T0 < 1 || T0 >= (1 << TW)) begin : g_bad_t0
      $error("interval_sequencer: T0 out of range 1..2^TW-1");
   end
   if (T1 < 1 || T1 >= (1 << TW)) begin : g_bad_t1
      $error("interval_sequencer: T1 out of range 1..2^TW-1");
   end
   if (T2 < 1 || T2 >= (1 << TW)) begin : g_bad_t2
      $error("interval_sequencer: T2 out of range 1..2^TW-1");
   end
   if (T3 < 1 || T3 >= (1 << TW)) begin : g_bad_t3
      $error("interval_sequencer: T3 out of range 1..2^TW-1");
   end

   state_t        state;
   logic [TW-1:0] tick_last;
   logic          last_tick;

   always_comb begin
      tick_last = TW'(ticks_for(phase, T0, T1, T2, T3) - 1);
      last_tick = (tick_cnt == tick_last);
   end

   // Strobes come straight from the state register so they never glitch
   // with en or tmr_end.
   assign tmr_start = (state == FIRE);
   assign running   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= PH0;
         tick_cnt   <= '0;
         phase_done <= 1'b0;
      end else begin
         phase_done <= 1'b0;
         case (state)
            IDLE: begin
               if (en && tmr_end) begin
                  state <= FIRE;
               end
            end
            FIRE: begin
               state <= ARM;
            end
            // tmr_end still reflects the idle timer here, so it is skipped.
            ARM: begin
               state <= WAIT;
            end
            WAIT: begin
               if (tmr_end) begin
                  if (last_tick) begin
                     tick_cnt   <= '0;
                     phase      <= phase + 2'd1;
                     phase_done <= 1'b1;
                     state      <= (hold || !en) ? IDLE : FIRE;
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                     state    <= en ? FIRE : IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interval_sequencer.sv
// Bench for interval_sequencer: behavioural down-counting timer beside the
// main instance, plus a second instance with tmr_end tied high and T0=2.
module tb_interval_sequencer;

   logic       clk;
   logic       rst;
   logic       en;
   logic       hold;
   logic       tmr_start;
   logic       tmr_end;
   logic [1:0] phase;
   logic [3:0] tick_cnt;
   logic       phase_done;
   logic       running;

   logic       rst2;
   logic       en2;
   logic       hold2;
   logic       tmr_start2;
   logic       tmr_end2;
   logic [1:0] phase2;
   logic [3:0] tick_cnt2;
   logic       phase_done2;
   logic       running2;

   interval_sequencer #(.TW(4), .T0(3), .T1(1), .T2(3), .T3(1)) dut (
      .clk(clk), .rst(rst), .en(en), .hold(hold),
      .tmr_start(tmr_start), .tmr_end(tmr_end),
      .phase(phase), .tick_cnt(tick_cnt),
      .phase_done(phase_done), .running(running)
   );

   interval_sequencer #(.TW(4), .T0(2), .T1(1), .T2(3), .T3(1)) dut2 (
      .clk(clk), .rst(rst2), .en(en2), .hold(hold2),
      .tmr_start(tmr_start2), .tmr_end(tmr_end2),
      .phase(phase2), .tick_cnt(tick_cnt2),
      .phase_done(phase_done2), .running(running2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timer model: load 5 on start, count down, end flag high at zero.
   logic [7:0] tcount = 8'd0;
   logic       force_busy = 1'b0;
   always @(posedge clk) begin
      if (tmr_start) tcount <= 8'd5;
      else if (tcount != 8'd0) tcount <= tcount - 8'd1;
   end
   assign tmr_end  = (tcount == 8'd0) && !force_busy;
   assign tmr_end2 = 1'b1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int st;
      int ph;
      int tk;
      int pd;
   } exp_t;

   int   sb_q[$];
   exp_t q2[$];
   bit   sb_on = 0;
   bit   q2_on = 0;
   int   cyc = 0;
   int   nstarts = 0;
   int   last_start = 0;
   bit   have_last = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tmr_start === 1'b1) begin
         nstarts++;
         if (sb_on) begin
            if (sb_q.size() == 0) check("sb_underflow", 1, 0);
            else check("sb_phase_at_start", 32'(phase), sb_q.pop_front());
            if (have_last) check("start_period", cyc - last_start, 7);
            last_start = cyc;
            have_last  = 1;
         end
      end
      if (q2_on && q2.size() != 0) begin
         exp_t e;
         e = q2.pop_front();
         check("t0_2_start", 32'(tmr_start2), e.st);
         check("t0_2_phase", 32'(phase2), e.ph);
         check("t0_2_tick", 32'(tick_cnt2), e.tk);
         check("t0_2_done", 32'(phase_done2), e.pd);
      end
   end

   initial begin
      int n0;
      int pd_cnt;
      bit flag;
      int exp_ph[9] = '{0, 0, 0, 1, 2, 2, 2, 3, 0};
      int e_st[10]  = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
      int e_ph[10]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
      int e_tk[10]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
      int e_pd[10]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

      rst = 1; en = 0; hold = 0;
      rst2 = 1; en2 = 0; hold2 = 0;
      repeat (3) step();
      rst = 0;
      step();
      check("reset_running", 32'(running), 0);
      check("reset_start", 32'(tmr_start), 0);
      check("reset_phase", 32'(phase), 0);
      check("reset_tick", 32'(tick_cnt), 0);
      check("reset_done", 32'(phase_done), 0);

      // Steady state with a N=5 timer: period 7, phase order per start.
      foreach (exp_ph[i]) sb_q.push_back(exp_ph[i]);
      sb_on = 1;
      en = 1;
      pd_cnt = 0;
      for (int k = 1; k <= 57; k++) begin
         step();
         if (k == 1) check("first_fire_latency", 32'(tmr_start), 1);
         if (k >= 2 && phase_done === 1'b1) pd_cnt++;
      end
      #5;
      sb_on = 0;
      check("sb_drained", sb_q.size(), 0);
      check("phase_done_count_56", pd_cnt, 4);

      // Reset in the middle of WAIT.
      step();
      step();
      check("pre_rst_running", 32'(running), 1);
      rst = 1;
      step();
      check("rst_running", 32'(running), 0);
      check("rst_start", 32'(tmr_start), 0);
      check("rst_phase", 32'(phase), 0);
      check("rst_tick", 32'(tick_cnt), 0);
      check("rst_done", 32'(phase_done), 0);
      n0 = nstarts;
      repeat (8) step();
      check("rst_no_start", nstarts - n0, 0);
      rst = 0;
      en = 0;

      // Busy timer keeps the block in IDLE.
      force_busy = 1;
      en = 1;
      n0 = nstarts;
      flag = 0;
      repeat (10) begin
         step();
         if (running !== 1'b0) flag = 1;
      end
      check("busy_left_idle", 32'(flag), 0);
      check("busy_no_start", nstarts - n0, 0);
      force_busy = 0;
      step();
      check("busy_release_fire", 32'(tmr_start), 1);

      // Drop en in WAIT of the second phase-0 interval.
      step();
      for (int i = 0; i < 20 && tmr_start !== 1'b1; i++) step();
      check("second_fire_seen", 32'(tmr_start), 1);
      step();
      step();
      en = 0;
      for (int i = 0; i < 20 && running !== 1'b0; i++) step();
      check("en_drop_idle", 32'(running), 0);
      check("en_drop_tick", 32'(tick_cnt), 2);
      check("en_drop_phase", 32'(phase), 0);
      check("en_drop_done", 32'(phase_done), 0);
      repeat (2) step();
      check("en_drop_parked_tick", 32'(tick_cnt), 2);
      en = 1;
      step();
      check("resume_fire", 32'(tmr_start), 1);
      n0 = nstarts;
      for (int i = 0; i < 20 && phase_done !== 1'b1; i++) step();
      check("resume_phase_done", 32'(phase_done), 1);
      check("resume_phase", 32'(phase), 1);
      check("resume_tick", 32'(tick_cnt), 0);
      check("resume_single_fire", nstarts - n0, 1);

      // hold across the end of phase 0.
      en = 0;
      rst = 1;
      repeat (2) step();
      rst = 0;
      repeat (10) step();
      hold = 1;
      en = 1;
      for (int i = 0; i < 80 && phase_done !== 1'b1; i++) step();
      check("hold_phase_done", 32'(phase_done), 1);
      check("hold_phase", 32'(phase), 1);
      check("hold_tick", 32'(tick_cnt), 0);
      check("hold_running", 32'(running), 0);
      check("hold_no_start", 32'(tmr_start), 0);
      hold = 0;
      step();
      check("hold_release_fire", 32'(tmr_start), 1);
      en = 0;

      // Second instance: tmr_end tied high, T0=2, three cycles per interval.
      rst2 = 0;
      step();
      for (int k = 0; k < 10; k++)
         q2.push_back('{st: e_st[k], ph: e_ph[k], tk: e_tk[k], pd: e_pd[k]});
      q2_on = 1;
      en2 = 1;
      repeat (10) step();
      q2_on = 0;
      check("t0_2_drained", q2.size(), 0);
      en2 = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
